// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite to APB3 bridge fanning single transfers out to NUM_SLV address-decoded slaves.
// Optional ACCESS-phase timeout enabled by defining AHB_APB_TIMEOUT_EN.
module ahb_apb_bridge_mslv #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_LSB     = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  Hclk,
  input  logic                  Hrstn,
  input  logic                  Hsel_APB,
  input  logic [1:0]            Htrans,
  input  logic                  Hwrite,
  input  logic [AW-1:0]         Haddr,
  input  logic [DW-1:0]         Hwdata,
  input  logic                  Hready_in,
  output logic                  Hready_out,
  output logic [1:0]            Hresp,
  output logic [DW-1:0]         Hrdata,
  output logic [AW-1:0]         Paddr,
  output logic                  Pwrite,
  output logic [DW-1:0]         Pwdata,
  output logic [NUM_SLV-1:0]    Psel,
  output logic                  Penable,
  input  logic [NUM_SLV*DW-1:0] Prdata,
  input  logic [NUM_SLV-1:0]    Pready,
  input  logic [NUM_SLV-1:0]    Pslverr
);
  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [IW:0] SLV_CNT = NUM_SLV[IW:0];

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       acc_idx;
  logic                acc_ok, accept, cur_rdy, cur_err, done_ok, done_err;
  logic [NUM_SLV-1:0]  acc_oh;
  logic                unused_ok;

  assign acc_idx  = Haddr[SLV_LSB +: IW];
  assign acc_ok   = ({1'b0, acc_idx} < SLV_CNT);
  assign acc_oh   = acc_ok ? (NUM_SLV'(1) << acc_idx) : '0;
  assign accept   = Hsel_APB & Htrans[1] & Hready_in & Hready_out;
  assign cur_rdy  = Pready[idx];
  assign cur_err  = Pslverr[idx];
  assign done_ok  = (state == ACCESS) & cur_rdy & ~cur_err;
  assign done_err = (state == ACCESS) & cur_rdy & cur_err;
  assign unused_ok = ^{Htrans[0], TIMEOUT_CYC[0]};

  // Write data is forwarded straight through; the master holds it while we stall.
  assign Pwdata = (Pwrite && (state == SETUP || state == ACCESS)) ? Hwdata : '0;

  // AHB response depends on the live Pready/Pslverr of the selected slave.
  always_comb begin
    Hready_out = 1'b1;
    Hresp      = 2'b00;
    Hrdata     = '0;
    case (state)
      SETUP:  Hready_out = 1'b0;
      ACCESS: begin
        Hready_out = done_ok;
        if (done_err) Hresp = 2'b01;
        if (done_ok && !Pwrite) Hrdata = Prdata[int'(idx)*DW +: DW];
      end
      ERR1: begin
        Hready_out = 1'b0;
        Hresp      = 2'b01;
      end
      ERR2:    Hresp = 2'b01;
      default: ;
    endcase
  end

`ifdef AHB_APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge Hclk or negedge Hrstn) begin
    if (!Hrstn) begin
      state   <= IDLE;
      Paddr   <= '0;
      Pwrite  <= 1'b0;
      idx     <= '0;
      Psel    <= '0;
      Penable <= 1'b0;
`ifdef AHB_APB_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      // Address phase capture; accept can only fire when Hready_out is high.
      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        idx    <= acc_idx;
      end
      case (state)
        IDLE, ERR2: begin
          if (accept) begin
            state <= acc_ok ? SETUP : ERR1;
            Psel  <= acc_oh;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          Penable <= 1'b1;
`ifdef AHB_APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (cur_rdy) begin
            Penable <= 1'b0;
            if (cur_err) begin
              state <= ERR1;
              Psel  <= '0;
            end else if (accept) begin
              state <= acc_ok ? SETUP : ERR1;
              Psel  <= acc_oh;
            end else begin
              state <= IDLE;
              Psel  <= '0;
            end
          end
`ifdef AHB_APB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state   <= ERR1;
            Psel    <= '0;
            Penable <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
